exram_bus_arbiter: RTL and testbench

Two-port arbiter and bus-cycle sequencer for the 8-bit external RAM bus. It accepts Avalon-style requests with waitrequest from two masters (port 0 and port 1). It grants one at a time, round-robin, and drives the external `wr_n`/`rd_n`/`addr`/`wdata` pins through programmable setup/strobe/hold phases, capturing `rdata` for reads. It sits between the system interconnect and the external RAM pins, replacing direct single-master pin registration.

---
 rtl/exram_bus_arbiter_pkg.sv | 27 ++
 rtl/exram_bus_arbiter_if.sv | 27 ++
 rtl/exram_bus_arbiter_rr_arb.sv | 25 ++
 rtl/exram_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_exram_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exram_bus_arbiter_pkg.sv
// Shared types and constants for the external RAM bus arbiter.
// Default pin widths and phase lengths live here so the top, the interface and benches agree.
package exram_pkg;

  localparam int unsigned EXRAM_ADDR_W     = 16;
  localparam int unsigned EXRAM_DATA_W     = 8;
  localparam int unsigned EXRAM_SETUP_CYC  = 1;
  localparam int unsigned EXRAM_STROBE_CYC = 2;
  localparam int unsigned EXRAM_HOLD_CYC   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } exram_state_t;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/exram_bus_arbiter_if.sv
// Avalon-style request port of one master into the external RAM arbiter.
interface exram_bus_arbiter_if
  import exram_pkg::*;
#(
  parameter int unsigned ADDR_W = EXRAM_ADDR_W,
  parameter int unsigned DATA_W = EXRAM_DATA_W
);

  logic              chipselect_n;
  logic              write_n;
  logic              read_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output chipselect_n, write_n, read_n, address, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect_n, write_n, read_n, address, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/exram_bus_arbiter_rr_arb.sv
// Two-request round-robin picker; remembers the last grant so contention alternates.
module exram_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       valid
);

  logic last;

  assign valid = |req;
  // Under contention the port not served last wins; otherwise the lone requester.
  assign grant = (&req) ? ~last : req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/exram_bus_arbiter.sv
// Two-port arbiter and setup/strobe/hold sequencer for the 8-bit external RAM pins.
module exram_bus_arbiter
  import exram_pkg::*;
#(
  parameter int unsigned ADDR_W     = EXRAM_ADDR_W,
  parameter int unsigned DATA_W     = EXRAM_DATA_W,
  parameter int unsigned SETUP_CYC  = EXRAM_SETUP_CYC,
  parameter int unsigned STROBE_CYC = EXRAM_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = EXRAM_HOLD_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  exram_bus_arbiter_if.slave  m0,
  exram_bus_arbiter_if.slave  m1,
  output logic                wr_n,
  output logic                rd_n,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  // Reload values are length-1; a phase of length 0 never loads its value.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  exram_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic              grant_q;
  logic              is_wr;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;

  logic [1:0]        req;
  logic              arb_grant;
  logic              arb_valid;
  logic              gnt_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  // Write takes precedence when a master lowers both write_n and read_n.
  assign req[0]    = !m0.chipselect_n && (!m0.write_n || !m0.read_n);
  assign req[1]    = !m1.chipselect_n && (!m1.write_n || !m1.read_n);
  assign gnt_wr    = arb_grant ? !m1.write_n : !m0.write_n;
  assign gnt_addr  = arb_grant ? m1.address : m0.address;
  assign gnt_wdata = arb_grant ? m1.writedata : m0.writedata;

  exram_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (state == IDLE && arb_valid),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  assign m0.waitrequest = req[0] && !(state == DONE && !grant_q);
  assign m1.waitrequest = req[1] && !(state == DONE && grant_q);
  assign m0.readdata    = rd0_q;
  assign m1.readdata    = rd1_q;

  // Bus-cycle sequencer: pins and readdata are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      grant_q <= 1'b0;
      is_wr   <= 1'b0;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      addr    <= '0;
      wdata   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            is_wr   <= gnt_wr;
            addr    <= gnt_addr;
            wdata   <= gnt_wdata;
            if (SETUP_CYC == 0) begin
              state <= STROBE;
              cnt   <= STROBE_LD;
              wr_n  <= !gnt_wr;
              rd_n  <= gnt_wr;
            end else begin
              state <= SETUP;
              cnt   <= SETUP_LD;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
            wr_n  <= !is_wr;
            rd_n  <= is_wr;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            wr_n <= 1'b1;
            rd_n <= 1'b1;
            if (!is_wr) begin
              if (grant_q) rd1_q <= rdata;
              else         rd0_q <= rdata;
            end
            if (HOLD_CYC == 0) begin
              state <= DONE;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_LD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exram_bus_arbiter.sv
// Bench for exram_bus_arbiter: directed accesses on a default-timing and a minimum-timing instance,
// with a completion scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_exram_bus_arbiter;
  import exram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  exram_bus_arbiter_if ma0 ();
  exram_bus_arbiter_if ma1 ();
  exram_bus_arbiter_if mb0 ();
  exram_bus_arbiter_if mb1 ();

  logic        wr_n_a, rd_n_a, wr_n_b, rd_n_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b, rdata_a, rdata_b, rd_val_a, rd_val_b;

  // External RAM model: drives the chosen value only while the read strobe is low.
  assign rdata_a = rd_n_a ? 8'hEE : rd_val_a;
  assign rdata_b = rd_n_b ? 8'hEE : rd_val_b;

  exram_bus_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .m0(ma0), .m1(ma1),
    .wr_n(wr_n_a), .rd_n(rd_n_a), .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a)
  );

  exram_bus_arbiter #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(mb0), .m1(mb1),
    .wr_n(wr_n_b), .rd_n(rd_n_b), .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b)
  );

  typedef struct {
    int          port;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    int          slen;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          s_len [2];
  bit          s_wr  [2];
  logic [15:0] s_a   [2];
  logic [7:0]  s_d   [2];

  logic done_a0, done_a1, done_b0, done_b1;
  assign done_a0 = !ma0.chipselect_n && (!ma0.write_n || !ma0.read_n) && !ma0.waitrequest;
  assign done_a1 = !ma1.chipselect_n && (!ma1.write_n || !ma1.read_n) && !ma1.waitrequest;
  assign done_b0 = !mb0.chipselect_n && (!mb0.write_n || !mb0.read_n) && !mb0.waitrequest;
  assign done_b1 = !mb1.chipselect_n && (!mb1.write_n || !mb1.read_n) && !mb1.waitrequest;

  task automatic mon(input int u, input logic wn, input logic rn, input logic [15:0] a,
                     input logic [7:0] d, input logic dn0, input logic dn1,
                     input logic [7:0] r0, input logic [7:0] r1);
    exp_t e;
    int   sz;
    if (!rst_n) begin
      s_len[u] = 0;
      return;
    end
    if (!wn || !rn) begin
      s_len[u]++;
      s_wr[u] = !wn;
      s_a[u]  = a;
      s_d[u]  = d;
    end
    if (dn0 || dn1) begin
      sz = (u == 0) ? qa.size() : qb.size();
      if (sz == 0) begin
        n_checks++;
        $display("FAIL unexpected completion: dut%0d port%0d got done, expected none", u, dn1);
      end else begin
        if (u == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk($sformatf("sb dut%0d grant port", u), 32'(dn1), 32'(e.port));
        chk($sformatf("sb dut%0d both done", u), 32'(dn0 && dn1), 32'(0));
        chk($sformatf("sb dut%0d direction", u), 32'(s_wr[u]), 32'(e.wr));
        chk($sformatf("sb dut%0d addr", u), 32'(s_a[u]), 32'(e.a));
        chk($sformatf("sb dut%0d wdata", u), 32'(s_d[u]), 32'(e.d));
        chk($sformatf("sb dut%0d strobe len", u), 32'(s_len[u]), 32'(e.slen));
        chk($sformatf("sb dut%0d m0 readdata", u), 32'(r0), 32'(e.rd0));
        chk($sformatf("sb dut%0d m1 readdata", u), 32'(r1), 32'(e.rd1));
      end
      s_len[u] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, wr_n_a, rd_n_a, addr_a, wdata_a, done_a0, done_a1, ma0.readdata, ma1.readdata);
    mon(1, wr_n_b, rd_n_b, addr_b, wdata_b, done_b0, done_b1, mb0.readdata, mb1.readdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int u, input int p, input bit on, input bit wr,
                         input logic [15:0] a, input logic [7:0] d);
    logic cs, w, r;
    cs = !on;
    w  = !(on && wr);
    r  = !(on && !wr);
    case ({u[0], p[0]})
      2'b00:   begin ma0.chipselect_n = cs; ma0.write_n = w; ma0.read_n = r; ma0.address = a; ma0.writedata = d; end
      2'b01:   begin ma1.chipselect_n = cs; ma1.write_n = w; ma1.read_n = r; ma1.address = a; ma1.writedata = d; end
      2'b10:   begin mb0.chipselect_n = cs; mb0.write_n = w; mb0.read_n = r; mb0.address = a; mb0.writedata = d; end
      default: begin mb1.chipselect_n = cs; mb1.write_n = w; mb1.read_n = r; mb1.address = a; mb1.writedata = d; end
    endcase
  endtask

  function automatic logic waitof(input int u, input int p);
    case ({u[0], p[0]})
      2'b00:   return ma0.waitrequest;
      2'b01:   return ma1.waitrequest;
      2'b10:   return mb0.waitrequest;
      default: return mb1.waitrequest;
    endcase
  endfunction

  function automatic logic [7:0] rdd(input int u, input int p);
    case ({u[0], p[0]})
      2'b00:   return ma0.readdata;
      2'b01:   return ma1.readdata;
      2'b10:   return mb0.readdata;
      default: return mb1.readdata;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the DONE cycle of port p, returning at the start of the following cycle.
  task automatic wait_done(input int u, input int p);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!waitof(u, p)) begin
        next_cycle();
        return;
      end
      next_cycle();
    end
    n_checks++;
    $display("FAIL timeout dut%0d port%0d: waitrequest stayed high, expected a DONE cycle", u, p);
  endtask

  task automatic master(input int u, input int p, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
    set_req(u, p, 1'b1, 1'b1, a0, d0);
    wait_done(u, p);
    set_req(u, p, 1'b1, 1'b1, a1, d1);
    wait_done(u, p);
    set_req(u, p, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  // Single access with cycle-by-cycle pin checks; expected phases come from s/st/h.
  task automatic timed(input int u, input int p, input bit wr, input logic [15:0] a,
                       input logic [7:0] d, input int s, input int st, input int h,
                       input logic [7:0] rd_old, input logic [7:0] rd_new);
    int   tot;
    bit   lo;
    logic wn, rn;
    logic [15:0] av;
    logic [7:0]  dv;
    tot = s + st + h + 2;
    set_req(u, p, 1'b1, wr, a, d);
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      lo = (c >= s + 1) && (c <= s + st);
      wn = (u == 0) ? wr_n_a : wr_n_b;
      rn = (u == 0) ? rd_n_a : rd_n_b;
      av = (u == 0) ? addr_a : addr_b;
      dv = (u == 0) ? wdata_a : wdata_b;
      chk($sformatf("dut%0d p%0d c%0d wr_n", u, p, c), 32'(wn), 32'(!(wr && lo)));
      chk($sformatf("dut%0d p%0d c%0d rd_n", u, p, c), 32'(rn), 32'(!(!wr && lo)));
      chk($sformatf("dut%0d p%0d c%0d waitrequest", u, p, c), 32'(waitof(u, p)), 32'(c != tot - 1));
      if (c >= 1 && c <= tot - 2) begin
        chk($sformatf("dut%0d p%0d c%0d addr", u, p, c), 32'(av), 32'(a));
        chk($sformatf("dut%0d p%0d c%0d wdata", u, p, c), 32'(dv), 32'(d));
      end
      if (!wr && c == s + st)
        chk($sformatf("dut%0d p%0d c%0d readdata before", u, p, c), 32'(rdd(u, p)), 32'(rd_old));
      if (!wr && c == s + st + 1)
        chk($sformatf("dut%0d p%0d c%0d readdata after", u, p, c), 32'(rdd(u, p)), 32'(rd_new));
      next_cycle();
    end
    set_req(u, p, 1'b0, 1'b0, 16'h0, 8'h0);
    next_cycle();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    rd_val_a = 8'h00;
    rd_val_b = 8'h00;
    for (int u = 0; u < 2; u++)
      for (int p = 0; p < 2; p++)
        set_req(u, p, 1'b0, 1'b0, 16'h0, 8'h0);

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset wr_n", 32'(wr_n_a), 32'(1));
    chk("reset rd_n", 32'(rd_n_a), 32'(1));
    chk("reset addr", 32'(addr_a), 32'(0));
    chk("reset wdata", 32'(wdata_a), 32'(0));
    chk("reset m0 readdata", 32'(ma0.readdata), 32'(0));
    chk("reset m1 readdata", 32'(ma1.readdata), 32'(0));
    chk("reset b wr_n", 32'(wr_n_b), 32'(1));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Port 0 write, default timing
    qa.push_back('{port: 0, wr: 1'b1, a: 16'h1234, d: 8'hA5, rd0: 8'h00, rd1: 8'h00, slen: 2});
    timed(0, 0, 1'b1, 16'h1234, 8'hA5, 1, 2, 1, 8'h00, 8'h00);

    // Port 1 read; m0 readdata must stay untouched
    rd_val_a = 8'h3C;
    qa.push_back('{port: 1, wr: 1'b0, a: 16'h00FF, d: 8'h5A, rd0: 8'h00, rd1: 8'h3C, slen: 2});
    timed(0, 1, 1'b0, 16'h00FF, 8'h5A, 1, 2, 1, 8'h00, 8'h3C);

    // Contention right after reset, each master re-requesting at once: order 0,1,0,1
    reset_pulse();
    qa.push_back('{port: 0, wr: 1'b1, a: 16'h0100, d: 8'h11, rd0: 8'h00, rd1: 8'h00, slen: 2});
    qa.push_back('{port: 1, wr: 1'b1, a: 16'h0200, d: 8'h21, rd0: 8'h00, rd1: 8'h00, slen: 2});
    qa.push_back('{port: 0, wr: 1'b1, a: 16'h0101, d: 8'h12, rd0: 8'h00, rd1: 8'h00, slen: 2});
    qa.push_back('{port: 1, wr: 1'b1, a: 16'h0201, d: 8'h22, rd0: 8'h00, rd1: 8'h00, slen: 2});
    fork
      master(0, 0, 16'h0100, 16'h0101, 8'h11, 8'h12);
      master(0, 1, 16'h0200, 16'h0201, 8'h21, 8'h22);
    join
    repeat (3) next_cycle();

    // Reset during STROBE aborts the read with no completion
    rd_val_a = 8'h55;
    set_req(0, 1, 1'b1, 1'b0, 16'h0300, 8'h00);
    repeat (3) @(negedge clk);
    chk("abort rd_n low in strobe", 32'(rd_n_a), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("abort rd_n async high", 32'(rd_n_a), 32'(1));
    chk("abort wr_n high", 32'(wr_n_a), 32'(1));
    chk("abort waitrequest held", 32'(ma1.waitrequest), 32'(1));
    next_cycle();
    set_req(0, 1, 1'b0, 1'b0, 16'h0, 8'h0);
    next_cycle();
    rst_n = 1'b1;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("abort m1 readdata", 32'(ma1.readdata), 32'(0));
    next_cycle();

    // Minimum timing instance: 3-cycle accesses
    qb.push_back('{port: 0, wr: 1'b1, a: 16'h0042, d: 8'h99, rd0: 8'h00, rd1: 8'h00, slen: 1});
    timed(1, 0, 1'b1, 16'h0042, 8'h99, 0, 1, 0, 8'h00, 8'h00);
    rd_val_b = 8'h77;
    qb.push_back('{port: 1, wr: 1'b0, a: 16'h0077, d: 8'h00, rd0: 8'h00, rd1: 8'h77, slen: 1});
    timed(1, 1, 1'b0, 16'h0077, 8'h00, 0, 1, 0, 8'h00, 8'h77);

    repeat (3) next_cycle();
    chk("scoreboard a drained", 32'(qa.size()), 32'(0));
    chk("scoreboard b drained", 32'(qb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
